// File: rtl/mux_pkg.sv
// mux_pkg: shared mode encoding and select-width helper
// for the scanning N-to-1 multiplexer.
package mux_pkg;

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_SCAN   = 1'b1
   } mode_e;

   function automatic int sel_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_next_ch.sv
// mux_next_ch: circular priority finder over the enable
// mask, starting at ptr; also flags the highest set bit.
module mux_next_ch
   import mux_pkg::*;
#(
   parameter int N_IN  = 8,
   parameter int SEL_W = 3
) (
   input  logic [N_IN-1:0]  ch_en,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] cur,
   output logic             found,
   output logic             is_last
);

   logic [SEL_W-1:0] w_hi;

   // first enabled channel at or after ptr, wrapping at N_IN
   always_comb begin
      int j;
      j     = 0;
      cur   = '0;
      found = 1'b0;
      for (int i = N_IN - 1; i >= 0; i--) begin
         j = int'(ptr) + i;
         if (j >= N_IN)
            j = j - N_IN;
         if (ch_en[SEL_W'(j)]) begin
            cur   = SEL_W'(j);
            found = 1'b1;
         end
      end
   end

   // highest enabled channel marks the end of a sweep
   always_comb begin
      w_hi = '0;
      for (int k = 0; k < N_IN; k++)
         if (ch_en[k])
            w_hi = SEL_W'(k);
   end

   assign is_last = found && (cur == w_hi);

endmodule

// File: rtl/mux_scan_nto1.sv
// mux_scan_nto1: registered N-to-1 mux, valid/ready output,
// manual or round-robin scan select. Option: MUX_SEL_ERR_EN.
module mux_scan_nto1
   import mux_pkg::*;
#(
   parameter  int N_IN  = 8,
   parameter  int W     = 8,
   localparam int SEL_W = sel_width(N_IN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_IN*W-1:0] in_data,
   input  logic              mode,
   input  logic [SEL_W-1:0]  sel,
   input  logic [N_IN-1:0]   ch_en,
   input  logic              out_ready,
   output logic [W-1:0]      out_data,
   output logic [SEL_W-1:0]  out_sel,
   output logic              out_valid,
   output logic              scan_wrap
`ifdef MUX_SEL_ERR_EN
   ,
   output logic              sel_err
`endif
);

   logic [W-1:0]     r_data;
   logic [SEL_W-1:0] r_sel;
   logic             r_valid;
   logic [SEL_W-1:0] r_ptr;
   logic             r_wrap;

   logic             w_scan;
   logic             w_load_ok;
   logic             w_has_src;
   logic [SEL_W-1:0] w_cur;
   logic             w_found;
   logic             w_last;
   logic [SEL_W-1:0] w_idx;
   logic [SEL_W-1:0] w_nxt;
   logic [W-1:0]     w_data;

   mux_next_ch #(
      .N_IN  (N_IN),
      .SEL_W (SEL_W)
   ) u_next (
      .ch_en   (ch_en),
      .ptr     (r_ptr),
      .cur     (w_cur),
      .found   (w_found),
      .is_last (w_last)
   );

   assign w_scan    = (mode_e'(mode) == MODE_SCAN);
   assign w_load_ok = !r_valid || out_ready;
   assign w_idx     = w_scan ? w_cur : sel;
   assign w_nxt     = (int'(w_cur) == N_IN - 1) ?
                      '0 : w_cur + SEL_W'(1);

`ifdef MUX_SEL_ERR_EN
   logic w_oor;
   logic r_err;
   assign w_oor     = (int'(sel) >= N_IN);
   assign w_has_src = w_scan ? w_found : !w_oor;
   assign sel_err   = r_err;

   // error pulse on a manual load attempt with bad select
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_err <= 1'b0;
      else
         r_err <= w_load_ok && !w_scan && w_oor;
   end
`else
   assign w_has_src = w_scan ? w_found : 1'b1;
`endif

   // channel data mux; unmatched (out-of-range) index gives 0
   always_comb begin
      w_data = '0;
      for (int k = 0; k < N_IN; k++)
         if (w_idx == SEL_W'(k))
            w_data = in_data[k*W +: W];
   end

   // output beat register, scan pointer and wrap pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data  <= '0;
         r_sel   <= '0;
         r_valid <= 1'b0;
         r_ptr   <= '0;
         r_wrap  <= 1'b0;
      end else begin
         r_wrap <= 1'b0;
         if (!w_scan)
            r_ptr <= '0;
         if (w_load_ok) begin
            if (w_has_src) begin
               r_data  <= w_data;
               r_sel   <= w_idx;
               r_valid <= 1'b1;
               if (w_scan) begin
                  r_ptr  <= w_nxt;
                  r_wrap <= w_last;
               end
            end else begin
               r_valid <= 1'b0;
            end
         end
      end
   end

   assign out_data  = r_data;
   assign out_sel   = r_sel;
   assign out_valid = r_valid;
   assign scan_wrap = r_wrap;

endmodule
